pll_supervisor: RTL and testbench
=================================

// Module: pll_supervisor
// PURPOSE
//  Consumer-side supervisor for the TMDS rPLL, running in the 27 MHz input-clock domain.
//  - Drives the PLL RESET pin.
//  - Qualifies the asynchronous LOCK output.
//  - Checks the frequency of CLKOUTD (nominally 27*9/2/60 = 2.025 MHz).
//  - Holds a system reset until the PLL is locked and on frequency.
//  - Retries bring-up a bounded number of times, then flags failure.
// PARAMETERS
//  PLL_RST_CYC   27     clkin cycles pll_reset is held high per attempt
//  LOCK_FILT     16     consecutive synced-high lock samples needed to qualify lock
//  LOCK_TIMEOUT  27000  clkin cycles allowed in S_WLOCK before the attempt fails
//  WINDOW        2700   measurement window length in clkin cycles (100 us)
//  EXP_EDGES     202    expected clkoutd rising edges per window
//  TOL           4      allowed |count - EXP_EDGES|; pass when the deviation is <= TOL
//  MAX_RETRY     3      failed attempts tolerated before S_FAIL
// PORTS
//  clkin       in   1   27 MHz reference clock; the only clock
//  reset       in   1   asynchronous, active-high reset
//  pll_lock    in   1   rPLL LOCK; asynchronous, passes through a 2-FF synchroniser
//  pll_clkd    in   1   rPLL CLKOUTD sampled as data; 2-FF sync plus a 3rd FF for edge detect
//  pll_reset   out  1   to rPLL RESET; active-high
//  sys_rst     out  1   active-high reset for downstream logic; low only in S_RUN
//  freq_ok     out  1   result of the last completed window compare
//  meas_count  out  16  edge count latched at the end of the last window
//  retry_cnt   out  2   failed attempts since the last entry to S_RUN
//  fail        out  1   sticky; high in S_FAIL
// BEHAVIOUR
//  Reset values
//  - pll_reset=1, sys_rst=1, freq_ok=0, meas_count=0, retry_cnt=0, fail=0.
//  - State S_PRST; all internal counters 0.
//  Lock filter
//  - lock_q sets after LOCK_FILT consecutive high synced samples.
//  - Any low synced sample clears lock_q and the filter counter in the same cycle.
//  Edge counter
//  - Increments on sync_d & ~sync_q (rising edge of the synced pll_clkd).
//  - Saturates at 16'hFFFF.
//  Window
//  - Window counter runs 0..WINDOW-1.
//  - On the terminal cycle, meas_count <= edges, including any edge seen that cycle.
//  - freq_ok <= (|edges - EXP_EDGES| <= TOL), computed on 17-bit signed arithmetic.
//  - The edge counter restarts at 0 on the next cycle.
//  - Window and edge counters are held at 0 outside S_MEAS and S_RUN.
//  FSM
//  - S_PRST: pll_reset=1.
//    - Leave after PLL_RST_CYC cycles for S_WLOCK; pll_reset=0 from the first S_WLOCK cycle.
//  - S_WLOCK:
//    - lock_q=1 -> S_MEAS, timeout counter cleared.
//    - Timeout reached -> attempt failure.
//  - S_MEAS: one window.
//    - Window end with freq_ok=1 -> S_RUN.
//    - Window end with freq_ok=0 -> attempt failure.
//    - lock_q drop at any time -> attempt failure.
//  - S_RUN: sys_rst=0; retry_cnt cleared on entry; windows run back-to-back.
//    - Any window with freq_ok=0 -> failure, S_PRST, sys_rst=1 in the next cycle.
//    - lock_q drop -> failure, S_PRST, sys_rst=1 in the next cycle.
//  - Attempt failure:
//    - retry_cnt < MAX_RETRY: retry_cnt++ and go to S_PRST.
//    - Otherwise: go to S_FAIL.
//  - S_FAIL: pll_reset=1, sys_rst=1, fail=1; exit only via reset.
//  Priority and reset
//  - A lock drop and a window end in the same cycle: the lock drop wins. meas_count and
//    freq_ok still update.
//  - Async reset in any state returns immediately to the reset values above.
//  - sys_rst is registered: it deasserts exactly one clkin cycle after the S_RUN entry edge.
// TESTING
//  1. Bring-up: lock rises 50 cycles after pll_reset falls; pll_clkd = 2.025 MHz.
//     -> pll_reset high for exactly 27 cycles; lock_q 16 cycles after synced lock.
//     -> meas_count in {202,203}, freq_ok=1, sys_rst falls 1 cycle later, retry_cnt=0.
//  2. Lock glitch: 10-cycle high pulse in S_WLOCK -> no lock_q, stay in S_WLOCK.
//     1-cycle low in S_RUN -> S_PRST, sys_rst=1, retry_cnt=1.
//  3. Wrong frequency: pll_clkd = 2.5 MHz (250 edges) -> freq_ok=0, meas_count=250.
//     Retries run until fail=1 after the 4th failed window.
//  4. Boundary: 198 and 206 edges -> freq_ok=1; 197 and 207 -> freq_ok=0.
//  5. No lock: pll_lock tied 0 -> each attempt times out after 27000 cycles.
//     fail=1 after 4 attempts, pll_reset stays high.
//  6. Async reset asserted mid-S_MEAS and mid-S_FAIL -> all outputs at reset values in the
//     same cycle; a clean bring-up follows after release.

Source files
------------

// File: rtl/pll_supervisor.sv
// pll_supervisor: bring-up and health supervisor for the TMDS rPLL.
// Runs entirely in the 27 MHz clkin domain. It pulses the PLL reset, qualifies
// the asynchronous LOCK, measures the CLKOUTD frequency over fixed windows,
// and holds downstream logic in reset until the PLL is locked and on frequency.
// Failed attempts are retried a bounded number of times before giving up.
module pll_supervisor #(
    parameter int PLL_RST_CYC  = 27,
    parameter int LOCK_FILT    = 16,
    parameter int LOCK_TIMEOUT = 27000,
    parameter int WINDOW       = 2700,
    parameter int EXP_EDGES    = 202,
    parameter int TOL          = 4,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        pll_lock,
    input  logic        pll_clkd,
    output logic        pll_reset,
    output logic        sys_rst,
    output logic        freq_ok,
    output logic [15:0] meas_count,
    output logic [1:0]  retry_cnt,
    output logic        fail
);

    localparam int PRST_W = $clog2(PLL_RST_CYC + 1);
    localparam int FILT_W = $clog2(LOCK_FILT + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);

    typedef enum logic [2:0] {
        S_PRST  = 3'd0,
        S_WLOCK = 3'd1,
        S_MEAS  = 3'd2,
        S_RUN   = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic              lock_s1_reg, lock_s2_reg;
    logic              clkd_s1_reg, clkd_s2_reg, clkd_s3_reg;
    logic [FILT_W-1:0] filt_cnt_reg;
    logic              lock_q_reg;
    logic [PRST_W-1:0] prst_cnt_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [WIN_W-1:0]  win_cnt_reg;
    logic [15:0]       edge_cnt_reg;
    logic [15:0]       meas_count_reg;
    logic              freq_ok_reg;
    logic [1:0]        retry_cnt_reg;
    logic              sys_rst_reg;

    logic              clkd_rise;
    logic [15:0]       edges_total;
    logic signed [16:0] dev;
    logic signed [16:0] dev_abs;
    logic              freq_pass;
    logic              win_active;
    logic              win_end;
    logic              prst_done;
    logic              to_done;
    logic              retry_ok;
    logic              attempt_fail;

    // Edge of the synchronised CLKOUTD, and the window total including this cycle's edge
    assign clkd_rise   = clkd_s2_reg & ~clkd_s3_reg;
    assign edges_total = (edge_cnt_reg == 16'hFFFF) ? edge_cnt_reg
                                                    : edge_cnt_reg + 16'(clkd_rise);

    // Signed deviation from the nominal count; a 17-bit range covers both directions
    assign dev       = $signed({1'b0, edges_total}) - $signed(17'(EXP_EDGES));
    assign dev_abs   = dev[16] ? -dev : dev;
    assign freq_pass = (dev_abs <= $signed(17'(TOL)));

    assign win_active = (state_reg == S_MEAS) || (state_reg == S_RUN);
    assign win_end    = win_active && (win_cnt_reg == WIN_W'(WINDOW - 1));
    assign prst_done  = (prst_cnt_reg == PRST_W'(PLL_RST_CYC - 1));
    assign to_done    = (to_cnt_reg == TO_W'(LOCK_TIMEOUT - 1));
    assign retry_ok   = (int'(retry_cnt_reg) < MAX_RETRY);

    // Two-stage synchronisers for LOCK and CLKOUTD, plus a third CLKOUTD stage for edge detect
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_s1_reg <= 1'b0;
            lock_s2_reg <= 1'b0;
            clkd_s1_reg <= 1'b0;
            clkd_s2_reg <= 1'b0;
            clkd_s3_reg <= 1'b0;
        end else begin
            lock_s1_reg <= pll_lock;
            lock_s2_reg <= lock_s1_reg;
            clkd_s1_reg <= pll_clkd;
            clkd_s2_reg <= clkd_s1_reg;
            clkd_s3_reg <= clkd_s2_reg;
        end
    end

    // Lock qualifier: needs an unbroken run of high samples, any low sample drops it at once
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            filt_cnt_reg <= '0;
            lock_q_reg   <= 1'b0;
        end else if (!lock_s2_reg) begin
            filt_cnt_reg <= '0;
            lock_q_reg   <= 1'b0;
        end else if (filt_cnt_reg != FILT_W'(LOCK_FILT)) begin
            filt_cnt_reg <= filt_cnt_reg + FILT_W'(1);
            if (filt_cnt_reg == FILT_W'(LOCK_FILT - 1)) begin
                lock_q_reg <= 1'b1;
            end
        end
    end

    // PLL reset pulse length and lock wait timeout counters, each live only in its own state
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            prst_cnt_reg <= '0;
            to_cnt_reg   <= '0;
        end else begin
            prst_cnt_reg <= (state_reg == S_PRST)  ? prst_cnt_reg + PRST_W'(1) : '0;
            to_cnt_reg   <= (state_reg == S_WLOCK) ? to_cnt_reg + TO_W'(1)     : '0;
        end
    end

    // Measurement window: count CLKOUTD edges, latch the result and restart on the terminal cycle
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            win_cnt_reg    <= '0;
            edge_cnt_reg   <= '0;
            meas_count_reg <= '0;
            freq_ok_reg    <= 1'b0;
        end else if (!win_active) begin
            win_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
        end else if (win_end) begin
            win_cnt_reg    <= '0;
            edge_cnt_reg   <= '0;
            meas_count_reg <= edges_total;
            freq_ok_reg    <= freq_pass;
        end else begin
            win_cnt_reg  <= win_cnt_reg + WIN_W'(1);
            edge_cnt_reg <= edges_total;
        end
    end

    // State register
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_reg <= S_PRST;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a lock drop outranks a window result in the same cycle
    always_comb begin
        state_next   = state_reg;
        attempt_fail = 1'b0;
        case (state_reg)
            S_PRST: begin
                if (prst_done) state_next = S_WLOCK;
            end
            S_WLOCK: begin
                if (lock_q_reg)   state_next   = S_MEAS;
                else if (to_done) attempt_fail = 1'b1;
            end
            S_MEAS: begin
                if (!lock_q_reg) begin
                    attempt_fail = 1'b1;
                end else if (win_end) begin
                    if (freq_pass) state_next   = S_RUN;
                    else           attempt_fail = 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_q_reg || (win_end && !freq_pass)) attempt_fail = 1'b1;
            end
            S_FAIL: begin
                state_next = S_FAIL;
            end
            default: begin
                state_next = S_PRST;
            end
        endcase
        if (attempt_fail) begin
            state_next = retry_ok ? S_PRST : S_FAIL;
        end
    end

    // Retry bookkeeping, and the registered system reset that trails S_RUN by one cycle
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            retry_cnt_reg <= '0;
            sys_rst_reg   <= 1'b1;
        end else begin
            if (attempt_fail && retry_ok) begin
                retry_cnt_reg <= retry_cnt_reg + 2'd1;
            end else if (state_next == S_RUN && state_reg != S_RUN) begin
                retry_cnt_reg <= '0;
            end
            sys_rst_reg <= (state_reg != S_RUN);
        end
    end

    // Outputs decoded from the current state and the registered status
    always_comb begin
        pll_reset  = (state_reg == S_PRST) || (state_reg == S_FAIL);
        fail       = (state_reg == S_FAIL);
        sys_rst    = sys_rst_reg;
        freq_ok    = freq_ok_reg;
        meas_count = meas_count_reg;
        retry_cnt  = retry_cnt_reg;
    end

endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: directed checks of PLL bring-up, lock qualification,
// frequency windows, retry/fail handling and asynchronous reset.
// CLKOUTD is modelled by a phase accumulator that yields exactly n_edges
// rising edges in any 2700 consecutive clkin cycles.
module tb_pll_supervisor;

    // Shortened lock timeout keeps the no-lock scenario's run time reasonable
    localparam int TB_TIMEOUT = 3000;
    localparam int RST_CYC    = 27;
    // Cycles from the lock-drive edge to the window-result edge:
    // 2 sync + 16 filter + 1 state change + 2700 window
    localparam int MEAS_LAT   = 2719;

    logic        clkin    = 1'b0;
    logic        reset    = 1'b1;
    logic        pll_lock = 1'b0;
    logic        pll_clkd = 1'b0;
    logic        pll_reset;
    logic        sys_rst;
    logic        freq_ok;
    logic [15:0] meas_count;
    logic [1:0]  retry_cnt;
    logic        fail;

    int checks = 0;
    int passes = 0;
    int n_edges = 202;
    int phase = 0;

    typedef struct {
        int   n;
        int   exp_meas;
        logic exp_ok;
    } vec_t;

    vec_t vecs [6];

    pll_supervisor #(
        .LOCK_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .pll_clkd   (pll_clkd),
        .pll_reset  (pll_reset),
        .sys_rst    (sys_rst),
        .freq_ok    (freq_ok),
        .meas_count (meas_count),
        .retry_cnt  (retry_cnt),
        .fail       (fail)
    );

    always #5 clkin = ~clkin;

    always @(posedge clkin) begin
        #1;
        phase = (phase + n_edges) % 2700;
        pll_clkd = (phase >= 1350);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
            $display("ok   %s: %0d", name, act);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Cycles until pll_reset leaves the given level
    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while (pll_reset == lvl && n < 40000) begin
            tick(1);
            n++;
        end
    endtask

    // Full bring-up from reset release with lock arriving 50 cycles after pll_reset falls
    task automatic bringup(input string tag, input int exp_meas, input logic exp_ok);
        int n;
        int c;
        count_level(1'b1, n);
        check({tag, "_prst_len"}, n, RST_CYC);
        tick(50);
        pll_lock = 1'b1;
        c = 0;
        while (meas_count == 16'd0 && c < 5000) begin
            tick(1);
            c++;
        end
        check({tag, "_meas_latency"}, c, MEAS_LAT);
        check({tag, "_meas_count"}, int'(meas_count), exp_meas);
        check({tag, "_freq_ok"}, int'(freq_ok), int'(exp_ok));
        check({tag, "_sys_rst_at_end"}, int'(sys_rst), 1);
        if (exp_ok) begin
            check({tag, "_retry_cnt"}, int'(retry_cnt), 0);
            tick(1);
            check({tag, "_sys_rst_next"}, int'(sys_rst), 0);
        end else begin
            check({tag, "_retry_cnt"}, int'(retry_cnt), 1);
            check({tag, "_pll_reset"}, int'(pll_reset), 1);
            tick(1);
            check({tag, "_sys_rst_next"}, int'(sys_rst), 1);
        end
    endtask

    // Assert reset between edges and check outputs before any clock edge
    task automatic async_reset_check(input string tag);
        #3;
        reset = 1'b1;
        pll_lock = 1'b0;
        #1;
        check({tag, "_rst_pll_reset"}, int'(pll_reset), 1);
        check({tag, "_rst_sys_rst"}, int'(sys_rst), 1);
        check({tag, "_rst_freq_ok"}, int'(freq_ok), 0);
        check({tag, "_rst_meas"}, int'(meas_count), 0);
        check({tag, "_rst_retry"}, int'(retry_cnt), 0);
        check({tag, "_rst_fail"}, int'(fail), 0);
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;

        vecs[0] = '{n: 202, exp_meas: 202, exp_ok: 1'b1};
        vecs[1] = '{n: 198, exp_meas: 198, exp_ok: 1'b1};
        vecs[2] = '{n: 206, exp_meas: 206, exp_ok: 1'b1};
        vecs[3] = '{n: 197, exp_meas: 197, exp_ok: 1'b0};
        vecs[4] = '{n: 207, exp_meas: 207, exp_ok: 1'b0};
        vecs[5] = '{n: 250, exp_meas: 250, exp_ok: 1'b0};

        // Reset values while reset is held
        tick(1);
        check("reset_pll_reset", int'(pll_reset), 1);
        check("reset_sys_rst", int'(sys_rst), 1);
        check("reset_freq_ok", int'(freq_ok), 0);
        check("reset_meas", int'(meas_count), 0);
        check("reset_retry", int'(retry_cnt), 0);
        check("reset_fail", int'(fail), 0);

        // Bring-up and window boundary vectors
        for (int i = 0; i < 6; i++) begin
            n_edges = vecs[i].n;
            pll_lock = 1'b0;
            do_reset();
            bringup($sformatf("vec%0d_n%0d", i, vecs[i].n), vecs[i].exp_meas, vecs[i].exp_ok);
        end

        // Short lock pulse in S_WLOCK is ignored, then a 1-cycle drop in S_RUN fails the run
        n_edges = 202;
        pll_lock = 1'b0;
        do_reset();
        count_level(1'b1, n);
        check("glitch_prst_len", n, RST_CYC);
        tick(5);
        pll_lock = 1'b1;
        tick(10);
        pll_lock = 1'b0;
        tick(40);
        check("glitch_still_wlock", int'(pll_reset), 0);
        check("glitch_no_meas", int'(meas_count), 0);
        check("glitch_sys_rst", int'(sys_rst), 1);
        pll_lock = 1'b1;
        c = 0;
        while (meas_count == 16'd0 && c < 5000) begin
            tick(1);
            c++;
        end
        check("glitch_relock_latency", c, MEAS_LAT);
        check("glitch_relock_freq_ok", int'(freq_ok), 1);
        tick(1);
        check("glitch_run_sys_rst", int'(sys_rst), 0);
        tick(100);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(3);
        check("drop_pll_reset", int'(pll_reset), 1);
        check("drop_retry", int'(retry_cnt), 1);
        check("drop_sys_rst_same", int'(sys_rst), 0);
        tick(1);
        check("drop_sys_rst_next", int'(sys_rst), 1);

        // Lock stays high, so the supervisor re-enters S_MEAS; reset in the middle of it
        tick(500);
        check("midmeas_pre_meas", int'(meas_count), 202);
        async_reset_check("midmeas");
        bringup("after_midmeas", 202, 1'b1);

        // Wrong frequency: every window fails until S_FAIL
        n_edges = 250;
        pll_lock = 1'b1;
        do_reset();
        for (int a = 1; a <= 3; a++) begin
            c = 0;
            while (int'(retry_cnt) != a && c < 10000) begin
                tick(1);
                c++;
            end
            check($sformatf("wrongf_retry%0d_seen", a), int'(c < 10000), 1);
            check($sformatf("wrongf_retry%0d_meas", a), int'(meas_count), 250);
            check($sformatf("wrongf_retry%0d_freq_ok", a), int'(freq_ok), 0);
            check($sformatf("wrongf_retry%0d_fail", a), int'(fail), 0);
        end
        c = 0;
        while (fail == 1'b0 && c < 10000) begin
            tick(1);
            c++;
        end
        check("wrongf_fail_seen", int'(fail), 1);
        check("wrongf_fail_retry", int'(retry_cnt), 3);
        check("wrongf_fail_pll_reset", int'(pll_reset), 1);
        tick(20);
        check("wrongf_fail_sticky", int'(fail), 1);
        check("wrongf_fail_sys_rst", int'(sys_rst), 1);
        n_edges = 202;
        async_reset_check("midfail");
        bringup("after_midfail", 202, 1'b1);

        // No lock at all: each attempt times out, fourth timeout enters S_FAIL
        pll_lock = 1'b0;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            count_level(1'b1, n);
            check($sformatf("nolock%0d_prst_len", a), n, RST_CYC);
            count_level(1'b0, n);
            check($sformatf("nolock%0d_wlock_len", a), n, TB_TIMEOUT);
            check($sformatf("nolock%0d_fail", a), int'(fail), int'(a == 3));
            check($sformatf("nolock%0d_retry", a), int'(retry_cnt), (a < 3) ? a + 1 : 3);
        end
        tick(200);
        check("nolock_pll_reset_held", int'(pll_reset), 1);
        check("nolock_fail_held", int'(fail), 1);
        check("nolock_sys_rst", int'(sys_rst), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
